// File: rtl/hdc_ngram_encoder_if.sv
// Symbol-in / hypervector-out bundle for hdc_ngram_encoder.
// Both streams use valid/ready: a transfer happens on a rising edge where valid && ready; a source holds its payload until that edge.
interface hdc_ngram_encoder_if #(
    parameter int D     = 10000,
    parameter int SYM_W = 8,
    parameter int CNT_W = 16
);
    logic [D-1:0]     seed_hv;
    logic             sym_valid;
    logic             sym_ready;
    logic [SYM_W-1:0] sym_data;
    logic             sym_last;
    logic             hv_valid;
    logic             hv_ready;
    logic [D-1:0]     hv_data;
    logic [CNT_W-1:0] hv_count;
    logic             hv_ovf;

    modport master (
        output seed_hv, sym_valid, sym_data, sym_last, hv_ready,
        input  sym_ready, hv_valid, hv_data, hv_count, hv_ovf
    );

    modport slave (
        input  seed_hv, sym_valid, sym_data, sym_last, hv_ready,
        output sym_ready, hv_valid, hv_data, hv_count, hv_ovf
    );
endinterface

// File: rtl/hdc_ngram_encoder.sv
// Streaming HDC N-gram encoder: rotated-seed items, XOR-bound N-grams, per-bit majority bundling.
// Optional macro HDC_ENC_SATURATE_EN: counters saturate and hv_ovf reports it; otherwise counters wrap and hv_ovf is 0.
module hdc_ngram_encoder #(
    parameter int D     = 10000,
    parameter int SYM_W = 8,
    parameter int NGRAM = 3,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hdc_ngram_encoder_if.slave     bus,
    output logic [1:0]             dbg_state
);
    localparam int FILL_W = $clog2(NGRAM);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NGRAM - 1);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FINAL = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [D-1:0]      hist [NGRAM-1];
    logic [FILL_W-1:0] fill;
    logic [CNT_W-1:0]  cnt [D];
    logic [CNT_W-1:0]  ngram_cnt;
    logic [D-1:0]      hv_data_q;
    logic [CNT_W-1:0]  hv_count_q;
    logic [D-1:0]      item;
    logic [D-1:0]      gram;
    logic [D-1:0]      thr;
    logic              accept;
    logic              bundle;

    function automatic logic [D-1:0] rotl(input logic [D-1:0] v, input int n);
        logic [2*D-1:0] w;
        w = {v, v} << n;
        return w[2*D-1:D];
    endfunction

    assign accept = bus.sym_valid && bus.sym_ready;
    assign bundle = accept && (fill == FILL_MAX);

    // Reset low forces sym_ready low even though the state already reads ACCUM.
    assign bus.sym_ready = rst_n && (state == ST_ACCUM);
    assign bus.hv_valid  = (state == ST_OUT);
    assign bus.hv_data   = hv_data_q;
    assign bus.hv_count  = hv_count_q;
    assign dbg_state     = state;

    always_comb begin
        item = rotl(bus.seed_hv, int'(bus.sym_data) % D);
        gram = item;
        for (int k = 0; k < NGRAM - 1; k++) begin
            gram = gram ^ rotl(hist[k], k + 1);
        end
    end

    // Majority per bit; a tie falls back to the seed bit, an empty message gives zeros.
    always_comb begin
        logic [CNT_W:0] twice;
        logic [CNT_W:0] ncmp;
        thr   = '0;
        twice = '0;
        ncmp  = {1'b0, ngram_cnt};
        for (int i = 0; i < D; i++) begin
            twice = {cnt[i], 1'b0};
            if (twice > ncmp)      thr[i] = 1'b1;
            else if (twice < ncmp) thr[i] = 1'b0;
            else                   thr[i] = bus.seed_hv[i];
        end
        if (ngram_cnt == '0) thr = '0;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_ACCUM: if (accept && bus.sym_last) state_next = ST_FINAL;
            ST_FINAL: state_next = ST_OUT;
            ST_OUT:   if (bus.hv_ready) state_next = ST_ACCUM;
            default:  state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_ACCUM;
        else        state <= state_next;
    end

`ifdef HDC_ENC_SATURATE_EN
    logic hv_ovf_q;
    logic sat_hit;

    always_comb begin
        sat_hit = bundle && (ngram_cnt == '1);
        for (int i = 0; i < D; i++) begin
            if (bundle && gram[i] && (cnt[i] == '1)) sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                                      hv_ovf_q <= 1'b0;
        else if (state == ST_OUT && bus.hv_ready)        hv_ovf_q <= 1'b0;
        else if (sat_hit)                                hv_ovf_q <= 1'b1;
    end

    assign bus.hv_ovf = hv_ovf_q;
`else
    assign bus.hv_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NGRAM - 1; k++) hist[k] <= '0;
            for (int i = 0; i < D; i++) cnt[i] <= '0;
            fill       <= '0;
            ngram_cnt  <= '0;
            hv_data_q  <= '0;
            hv_count_q <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        hist[0] <= item;
                        for (int k = 1; k < NGRAM - 1; k++) hist[k] <= hist[k-1];
                        if (fill != FILL_MAX) fill <= fill + FILL_ONE;
                    end
                    if (bundle) begin
`ifdef HDC_ENC_SATURATE_EN
                        for (int i = 0; i < D; i++) begin
                            if (gram[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_ONE;
                        end
                        if (ngram_cnt != '1) ngram_cnt <= ngram_cnt + CNT_ONE;
`else
                        for (int i = 0; i < D; i++) begin
                            if (gram[i]) cnt[i] <= cnt[i] + CNT_ONE;
                        end
                        ngram_cnt <= ngram_cnt + CNT_ONE;
`endif
                    end
                end
                ST_FINAL: begin
                    hv_data_q  <= thr;
                    hv_count_q <= ngram_cnt;
                    for (int k = 0; k < NGRAM - 1; k++) hist[k] <= '0;
                    for (int i = 0; i < D; i++) cnt[i] <= '0;
                    fill      <= '0;
                    ngram_cnt <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
